// File: rtl/seq_detect_counter.sv
// Serial pattern detector with a runtime-reloadable pattern and a match counter.
// The detection state is the longest suffix of accepted bits that is also a pattern prefix.
module seq_detect_counter #(
  parameter int               PAT_W    = 3,
  parameter logic [PAT_W-1:0] PATTERN  = 3'b010,
  parameter int               CNT_W    = 10,
  parameter bit               OVERLAP  = 1'b1,
  parameter bit               SATURATE = 1'b1,
  localparam int              LEN_W    = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             clr_cnt,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             y,
  output logic [CNT_W-1:0] users_count,
  output logic             cnt_sat,
  output logic [LEN_W-1:0] match_len
);

  // Handshake: x is consumed on a rising edge only while x_valid is high; there is no
  // backpressure, so every valid bit is accepted unless a pattern load claims the same edge.

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_d;
  logic [CNT_W-1:0] cnt_d;
  logic             hit;
  int               nl;

  // Pattern bit i (i = 0 is the first-received bit) lives at p[PAT_W-1-i].
  function automatic int next_len(input logic [PAT_W-1:0] p, input int len, input logic b);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k <= PAT_W; k++) begin
      if (k <= len + 1) begin
        ok = (p[PAT_W-k] == b);
        for (int j = 0; j < PAT_W - 1; j++) begin
          if (j < k - 1) begin
            if (p[PAT_W-1-j] != p[PAT_W-2-len+k-j]) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  function automatic int border(input logic [PAT_W-1:0] p);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < PAT_W; k++) begin
      ok = 1'b1;
      for (int i = 0; i < PAT_W - 1; i++) begin
        if (i < k) begin
          if (p[PAT_W-1-i] != p[k-1-i]) ok = 1'b0;
        end
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  always_comb begin
    nl    = next_len(pat_q, int'(match_len), x);
    hit   = x_valid && !pat_load && (nl == PAT_W);
    len_d = LEN_W'(nl);
    if (hit) len_d = OVERLAP ? LEN_W'(border(pat_q)) : '0;
    cnt_d = users_count;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (hit) begin
      if (!(SATURATE && (users_count == '1))) cnt_d = users_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q       <= PATTERN;
      match_len   <= '0;
      y           <= 1'b0;
      users_count <= '0;
      cnt_sat     <= 1'b0;
    end else begin
      if (pat_load) begin
        pat_q     <= pat_in;
        match_len <= '0;
        y         <= 1'b0;
      end else if (x_valid) begin
        match_len <= len_d;
        y         <= hit;
      end else begin
        y <= 1'b0;
      end
      users_count <= cnt_d;
      cnt_sat     <= SATURATE && (cnt_d == '1);
    end
  end

endmodule

// File: tb/tb_seq_detect_counter.sv
// Directed bench for seq_detect_counter: four instances (overlap, non-overlap,
// 3-bit saturating, 3-bit wrapping) share one stimulus stream.
module tb_seq_detect_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       x, x_valid, clr_cnt, pat_load;
  logic [2:0] pat_in;

  logic       y_ov, y_nov, y_sat, y_wrap;
  logic [9:0] cnt_ov, cnt_nov;
  logic [2:0] cnt_sat3, cnt_wrap3;
  logic       sat_ov, sat_nov, sat_sat, sat_wrap;
  logic [1:0] len_ov, len_nov, len_sat, len_wrap;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_detect_counter u_ov (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clr_cnt(clr_cnt),
    .pat_load(pat_load), .pat_in(pat_in), .y(y_ov), .users_count(cnt_ov),
    .cnt_sat(sat_ov), .match_len(len_ov)
  );

  seq_detect_counter #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clr_cnt(clr_cnt),
    .pat_load(pat_load), .pat_in(pat_in), .y(y_nov), .users_count(cnt_nov),
    .cnt_sat(sat_nov), .match_len(len_nov)
  );

  seq_detect_counter #(.CNT_W(3), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clr_cnt(clr_cnt),
    .pat_load(pat_load), .pat_in(pat_in), .y(y_sat), .users_count(cnt_sat3),
    .cnt_sat(sat_sat), .match_len(len_sat)
  );

  seq_detect_counter #(.CNT_W(3), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clr_cnt(clr_cnt),
    .pat_load(pat_load), .pat_in(pat_in), .y(y_wrap), .users_count(cnt_wrap3),
    .cnt_sat(sat_wrap), .match_len(len_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic b, input logic v, input logic clr, input logic ld,
                       input logic [2:0] pin);
    @(negedge clk);
    x = b; x_valid = v; clr_cnt = clr; pat_load = ld; pat_in = pin;
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    drive(b, 1'b1, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    x = 1'b0; x_valid = 1'b0; clr_cnt = 1'b0; pat_load = 1'b0; pat_in = 3'b000;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [4:0] s1;
    logic [4:0] y_ov_exp, y_nov_exp;
    rst = 1'b0; x = 1'b0; x_valid = 1'b0; clr_cnt = 1'b0; pat_load = 1'b0; pat_in = 3'b000;
    #1;
    chk("reset_y", {31'd0, y_ov}, 32'd0);
    chk("reset_count", {22'd0, cnt_ov}, 32'd0);
    chk("reset_len", {30'd0, len_ov}, 32'd0);
    chk("reset_sat", {31'd0, sat_ov}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Overlapping vs non-overlapping on 0,1,0,1,0
    s1 = 5'b01010; y_ov_exp = 5'b00101; y_nov_exp = 5'b00100;
    for (int i = 0; i < 5; i++) begin
      bit_in(s1[4-i]);
      chk($sformatf("t1_y_ov_bit%0d", i + 1), {31'd0, y_ov}, {31'd0, y_ov_exp[4-i]});
      chk($sformatf("t2_y_nov_bit%0d", i + 1), {31'd0, y_nov}, {31'd0, y_nov_exp[4-i]});
      if (i == 2) chk("t2_len_nov_after_match", {30'd0, len_nov}, 32'd0);
    end
    chk("t1_count_ov", {22'd0, cnt_ov}, 32'd2);
    chk("t1_len_ov", {30'd0, len_ov}, 32'd1);
    chk("t2_count_nov", {22'd0, cnt_nov}, 32'd1);

    // Valid gaps: the unqualified 1 must be ignored
    do_reset();
    bit_in(1'b0);
    chk("t3_y_a", {31'd0, y_ov}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    chk("t3_y_gap", {31'd0, y_ov}, 32'd0);
    chk("t3_len_gap", {30'd0, len_ov}, 32'd1);
    bit_in(1'b1);
    chk("t3_y_b", {31'd0, y_ov}, 32'd0);
    bit_in(1'b0);
    chk("t3_y_match", {31'd0, y_ov}, 32'd1);
    chk("t3_count", {22'd0, cnt_ov}, 32'd1);

    // Saturating and wrapping 3-bit counters: 0 then (1,0) x9 gives nine matches
    do_reset();
    bit_in(1'b0);
    for (int m = 1; m <= 9; m++) begin
      bit_in(1'b1);
      bit_in(1'b0);
      if (m == 7) begin
        chk("t4_sat_count7", {29'd0, cnt_sat3}, 32'd7);
        chk("t4_sat_flag7", {31'd0, sat_sat}, 32'd1);
        chk("t4_wrap_count7", {29'd0, cnt_wrap3}, 32'd7);
        chk("t4_wrap_flag7", {31'd0, sat_wrap}, 32'd0);
      end
      if (m == 8) begin
        chk("t4_wrap_count8", {29'd0, cnt_wrap3}, 32'd0);
        chk("t4_wrap_flag8", {31'd0, sat_wrap}, 32'd0);
      end
    end
    chk("t4_sat_count9", {29'd0, cnt_sat3}, 32'd7);
    chk("t4_sat_flag9", {31'd0, sat_sat}, 32'd1);
    chk("t4_y_sat9", {31'd0, y_sat}, 32'd1);
    chk("t4_count_ov9", {22'd0, cnt_ov}, 32'd9);

    // Pattern reload: the same-edge 0 would have completed 010 and must be discarded
    do_reset();
    bit_in(1'b0);
    bit_in(1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b110);
    chk("t5_load_y", {31'd0, y_ov}, 32'd0);
    chk("t5_load_len", {30'd0, len_ov}, 32'd0);
    chk("t5_load_count", {22'd0, cnt_ov}, 32'd0);
    s1 = 5'b11000; y_ov_exp = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      bit_in(s1[4-i]);
      chk($sformatf("t5_110_bit%0d", i + 1), {31'd0, y_ov}, {31'd0, y_ov_exp[4-i]});
    end
    chk("t5_count_after_110", {22'd0, cnt_ov}, 32'd1);
    s1 = 5'b01000;
    for (int i = 0; i < 3; i++) begin
      bit_in(s1[4-i]);
      chk($sformatf("t5_010_bit%0d", i + 1), {31'd0, y_ov}, 32'd0);
    end
    chk("t5_count_after_010", {22'd0, cnt_ov}, 32'd1);

    // Asynchronous reset mid-cycle after a partial match
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b010);
    bit_in(1'b0);
    bit_in(1'b1);
    chk("t6_len_before_rst", {30'd0, len_ov}, 32'd2);
    #3 rst = 1'b0;
    #1;
    chk("t6_async_y", {31'd0, y_ov}, 32'd0);
    chk("t6_async_count", {22'd0, cnt_ov}, 32'd0);
    chk("t6_async_len", {30'd0, len_ov}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bit_in(1'b0);
    chk("t6_no_pulse", {31'd0, y_ov}, 32'd0);
    chk("t6_len_after", {30'd0, len_ov}, 32'd1);
    bit_in(1'b1);
    bit_in(1'b0);
    chk("t6_default_pattern_y", {31'd0, y_ov}, 32'd1);
    chk("t6_count_one", {22'd0, cnt_ov}, 32'd1);

    // Clear on a match edge: y still pulses, counter goes to zero
    bit_in(1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
    chk("t6_clr_y", {31'd0, y_ov}, 32'd1);
    chk("t6_clr_count", {22'd0, cnt_ov}, 32'd0);
    bit_in(1'b1);
    chk("t6_y_drops", {31'd0, y_ov}, 32'd0);
    chk("t6_count_held", {22'd0, cnt_ov}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
